// File: rtl/cnn_window_gen.sv
// 3x3 sliding-window generator for a raster-scan image with a fixed zero border.
// Two line buffers plus a 3x3 shift window; a registered output slot with valid/ready.
module cnn_window_gen #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        u_in,
    input  logic signed [8:0] y_in,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [7:0]        U1,
    output logic [7:0]        U2,
    output logic [7:0]        U3,
    output logic [7:0]        U4,
    output logic [7:0]        U5,
    output logic [7:0]        U6,
    output logic [7:0]        U7,
    output logic [7:0]        U8,
    output logic [7:0]        U9,
    output logic signed [8:0] Y1,
    output logic signed [8:0] Y2,
    output logic signed [8:0] Y3,
    output logic signed [8:0] Y4,
    output logic signed [8:0] Y5,
    output logic signed [8:0] Y6,
    output logic signed [8:0] Y7,
    output logic signed [8:0] Y8,
    output logic signed [8:0] Y9,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic              win_last
);
    localparam int IW = $clog2(IMG_H + 1);
    localparam int JW = $clog2(IMG_W + 1);
    localparam logic [IW-1:0] I_END  = IW'(IMG_H);
    localparam logic [IW-1:0] I_LAST = IW'(IMG_H - 1);
    localparam logic [JW-1:0] J_END  = JW'(IMG_W);
    localparam logic [JW-1:0] J_LAST = JW'(IMG_W - 1);

    typedef struct packed {
        logic [7:0] u;
        logic [8:0] y;
    } pix_t;

    logic [IW-1:0] i, ci;
    logic [JW-1:0] j, cj;
    pix_t lb0 [IMG_W+1];
    pix_t lb1 [IMG_W+1];
    pix_t win  [3][3];
    pix_t nwin [3][3];
    pix_t ocell [9];
    pix_t wout  [9];
    pix_t px;
    logic needs_in, emits, out_ok, step, mask_ok;

    always_comb begin
        needs_in = (i < I_END) && (j < J_END);
        emits    = (i != '0) && (j != '0);
        out_ok   = !emits || !win_valid || win_ready;
        step     = (!needs_in || in_valid) && out_ok && !rst;
        in_ready = needs_in && out_ok && !rst;
        px       = needs_in ? {u_in, y_in} : '0;
        ci       = i - 1'b1;
        cj       = j - 1'b1;
        mask_ok  = 1'b0;
        // New column enters on the right: rows i-2, i-1, i of column j.
        for (int r = 0; r < 3; r++) begin
            nwin[r][0] = win[r][1];
            nwin[r][1] = win[r][2];
        end
        nwin[0][2] = lb1[j];
        nwin[1][2] = lb0[j];
        nwin[2][2] = px;
        // Border zeros come from the centre coordinate, so stale buffer data never leaks.
        for (int k = 0; k < 9; k++) begin
            mask_ok = !((k / 3 == 0) && (ci == '0))     && !((k / 3 == 2) && (ci == I_LAST)) &&
                      !((k % 3 == 0) && (cj == '0))     && !((k % 3 == 2) && (cj == J_LAST));
            ocell[k] = mask_ok ? nwin[k / 3][k % 3] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i         <= '0;
            j         <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            for (int k = 0; k < 9; k++) wout[k] <= '0;
        end else begin
            if (step) begin
                if (j == J_END) begin
                    j <= '0;
                    i <= (i == I_END) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
            if (step && emits) begin
                win_valid <= 1'b1;
                win_row   <= 8'(ci);
                win_col   <= 8'(cj);
                win_last  <= (ci == I_LAST) && (cj == J_LAST);
                for (int k = 0; k < 9; k++) wout[k] <= ocell[k];
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    // Line buffers and the shift window carry no reset; masking makes their contents don't-care.
    always_ff @(posedge clk) begin
        if (step) begin
            lb1[j] <= lb0[j];
            lb0[j] <= px;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= nwin[r][c];
        end
    end

    assign U1 = wout[0].u;
    assign U2 = wout[1].u;
    assign U3 = wout[2].u;
    assign U4 = wout[3].u;
    assign U5 = wout[4].u;
    assign U6 = wout[5].u;
    assign U7 = wout[6].u;
    assign U8 = wout[7].u;
    assign U9 = wout[8].u;
    assign Y1 = wout[0].y;
    assign Y2 = wout[1].y;
    assign Y3 = wout[2].y;
    assign Y4 = wout[3].y;
    assign Y5 = wout[4].y;
    assign Y6 = wout[5].y;
    assign Y7 = wout[6].y;
    assign Y8 = wout[7].y;
    assign Y9 = wout[8].y;
endmodule

// File: doc/cnn_window_gen.md
CNN_WINDOW_GEN -- requirements
Module: cnn_window_gen

Interface
REQ-001 The block SHALL take parameter IMG_W, default 16, meaning image width in cells (range 2..256).
REQ-002 The block SHALL take parameter IMG_H, default 16, meaning image height in cells (range 2..256).
REQ-003 The port list SHALL be as follows, one port per line:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel offered.
- in_ready  out  1  pixel accepted this cycle when in_valid is also high.
- u_in  in  8  input value U of the pixel, unsigned.
- y_in  in  9  state value Y of the pixel, signed.
- win_valid  out  1  window outputs hold a valid neighbourhood.
- win_ready  in  1  downstream cell consumes the window.
- U1..U9  out  8 each  3x3 input neighbourhood.
- Y1..Y9  out  9 each, signed  3x3 state neighbourhood.
- win_row  out  8  row index of the centre cell.
- win_col  out  8  column index of the centre cell.
- win_last  out  1  the window is the final one of the frame.

Function
REQ-004 Pixels SHALL arrive in raster order, row 0 first, column 0 first, IMG_W*IMG_H per frame.
REQ-005 Neighbour numbering SHALL be row-major, with (r,c) the centre:
- 1=(r-1,c-1), 2=(r-1,c), 3=(r-1,c+1)
- 4=(r,c-1), 5=centre, 6=(r,c+1)
- 7=(r+1,c-1), 8=(r+1,c), 9=(r+1,c+1)
REQ-006 Any neighbour outside the image SHALL output U=0 and Y=0 (fixed zero boundary), applied by masking on the centre coordinate, never by buffer contents.
REQ-007 An internal scan position (i,j) SHALL step over an extended grid i=0..IMG_H, j=0..IMG_W in raster order.
REQ-008 A position with i<IMG_H and j<IMG_W SHALL consume one input pixel; any other position SHALL inject zero and consume nothing.
REQ-009 A step SHALL occur in a cycle only when both hold:
- the position needs no input, or in_valid=1;
- the position emits no window, or the output slot is free (win_valid=0 or win_ready=1).
REQ-010 in_ready SHALL equal 1 exactly when the current position consumes input, the output condition of REQ-009 holds, and rst=0.
REQ-011 A step at (i,j) with i>=1 and j>=1 SHALL load the window centred at (i-1,j-1), with win_row/win_col set, into the output registers on that clock edge.
REQ-012 win_valid SHALL rise the following cycle and hold, with all outputs stable, until win_ready=1.
REQ-013 Exactly IMG_W*IMG_H windows SHALL be emitted per frame, in raster order of centre.
REQ-014 win_last SHALL be 1 only with the window centred at (IMG_H-1, IMG_W-1).
REQ-015 Sustained throughput SHALL be one step per cycle while in_valid=1 and win_ready=1; each frame takes (IMG_H+1)*(IMG_W+1) steps.
REQ-016 Storage SHALL be two line buffers of IMG_W+1 entries of {u,y} (17 bits), plus a 3x3 shift window.
REQ-017 After position (IMG_H, IMG_W), the scan SHALL wrap to (0,0) with no idle cycle, and the next frame's first pixel SHALL be acceptable the next cycle.
REQ-018 Values SHALL pass through bit-exact; no arithmetic is applied to U or Y.
REQ-019 A held window SHALL not change when in_valid toggles or when win_ready=0.

Reset
REQ-020 While rst=1 the block SHALL hold:
- in_ready=0, win_valid=0, win_last=0;
- U1..U9=0, Y1..Y9=0, win_row=0, win_col=0;
- scan position (0,0).
REQ-021 Line-buffer contents SHALL need no reset.
REQ-022 rst asserted mid-frame SHALL discard the partial frame and any held window; the first pixel accepted after release is cell (0,0).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- 4x4 frame, U=r*4+c, Y=-(r*4+c), win_ready=1 -> 16 windows; centre (1,1): U1..U9=0,1,2,4,5,6,8,9,10.
- Same frame, corner (0,0) -> U1,U2,U3,U4,U7=0, U5=0, U6=1, U8=4, U9=5; corner (3,3) -> U9=0, U5=15, win_last=1.
- win_ready=0 for 10 cycles mid-frame -> outputs frozen, in_ready drops once the next step would emit, no pixel lost or duplicated.
- in_valid gaps (random 50%) -> window sequence identical to the gap-free run.
- Y=-256 and Y=+255 injected -> passed unchanged at the matching neighbour slots.
- rst after 7 pixels of a frame -> win_valid=0 next cycle; a fresh full frame then yields windows starting at centre (0,0) with correct values.
